// File: rtl/ga_mutation_sched.sv
// Pops queued child chromosomes, optionally flips LFSR-chosen bits one per cycle,
// and presents the result downstream while counting accepted mutated children.
module ga_mutation_sched #(
    parameter int CHROM_W   = 16,
    parameter int IDX_W     = 4,
    parameter int MAX_FLIPS = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sw_rst,
    input  logic [2:0]         cfg_num_flips,
    input  logic [15:0]        cfg_seed,
    input  logic               cfg_seed_load,
    input  logic               queue_empty,
    input  logic [CHROM_W-1:0] queue_chrom,
    input  logic               queue_chrom_sel,
    output logic               queue_pop,
    output logic               out_valid,
    output logic [CHROM_W-1:0] out_chrom,
    input  logic               out_ack,
    output logic               busy,
    output logic [15:0]        mut_cnt,
    output logic [1:0]         fsm_state
);
    // Handshake: out_chrom is offered while out_valid is high and held stable;
    // a transfer happens on a cycle with out_valid & out_ack both high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLIP = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [2:0]  MAX_F     = 3'(MAX_FLIPS);

    state_t             state;
    logic [CHROM_W-1:0] work_r;
    logic [2:0]         nflips_r;
    logic [2:0]         flip_cnt_r;
    logic               mut_r;
    logic [15:0]        lfsr_r;

    logic [2:0]         nflips_clamped;
    logic [CHROM_W-1:0] flip_mask;
    logic [15:0]        lfsr_adv;
    logic [15:0]        seed_val;
    logic [15:0]        mut_cnt_nxt;

    always_comb begin
        nflips_clamped = cfg_num_flips;
        if (cfg_num_flips == 3'd0) begin
            nflips_clamped = 3'd1;
        end else if (cfg_num_flips > MAX_F) begin
            nflips_clamped = MAX_F;
        end
    end

    assign flip_mask = {{(CHROM_W-1){1'b0}}, 1'b1} << lfsr_r[IDX_W-1:0];
    assign lfsr_adv  = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_TAPS : 16'h0000);
    // A zero seed would lock the LFSR, so it falls back to the reset value.
    assign seed_val  = (cfg_seed == 16'h0000) ? LFSR_INIT : cfg_seed;

    assign queue_pop = (state == IDLE) && !queue_empty && !sw_rst;
    assign out_valid = (state == SEND);
    assign out_chrom = work_r;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            work_r     <= '0;
            nflips_r   <= 3'd1;
            flip_cnt_r <= 3'd0;
            mut_r      <= 1'b0;
            lfsr_r     <= LFSR_INIT;
        end else if (sw_rst) begin
            state      <= IDLE;
            work_r     <= '0;
            nflips_r   <= 3'd1;
            flip_cnt_r <= 3'd0;
            mut_r      <= 1'b0;
            lfsr_r     <= LFSR_INIT;
        end else begin
            if (cfg_seed_load) begin
                lfsr_r <= seed_val;
            end else if (state == FLIP) begin
                lfsr_r <= lfsr_adv;
            end
            case (state)
                IDLE: begin
                    if (!queue_empty) begin
                        work_r     <= queue_chrom;
                        nflips_r   <= nflips_clamped;
                        flip_cnt_r <= 3'd0;
                        mut_r      <= queue_chrom_sel;
                        state      <= queue_chrom_sel ? FLIP : SEND;
                    end
                end
                FLIP: begin
                    work_r <= work_r ^ flip_mask;
                    if (flip_cnt_r == nflips_r - 3'd1) begin
                        state <= SEND;
                    end else begin
                        flip_cnt_r <= flip_cnt_r + 3'd1;
                    end
                end
                SEND: begin
                    if (out_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mut_cnt_nxt = mut_cnt;
        if ((state == SEND) && out_ack && mut_r && (mut_cnt != 16'hFFFF)) begin
            mut_cnt_nxt = mut_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mut_cnt <= 16'h0000;
        end else if (sw_rst) begin
            mut_cnt <= 16'h0000;
        end else begin
            mut_cnt <= mut_cnt_nxt;
        end
    end
endmodule
